// File: rtl/data_bus_responder.sv
// Data-memory responder for MiniMIPS32: byte-writable RAM plus an MMIO page
// with TX byte FIFO, STATUS, free-running CYCLE counter and SCRATCH register.
//
// Ports:
//   cpu_clk_50M, cpu_rst_n (async, active low)
//   daddr, dce, we[3:0], din : core request (we==0 with dce=1 is a read)
//   dm                        : read data, registered (1-cycle latency)
//   tx_valid, tx_data, tx_ready : FIFO drain handshake
module data_bus_responder #(
  parameter int          RAM_AW    = 12,
  parameter int          FIFO_AW   = 3,
  parameter logic [15:0] MMIO_PAGE = 16'hBFD0
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic [31:0] daddr,
  input  logic        dce,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] dm,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int RAM_DEPTH  = 1 << RAM_AW;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  logic [31:0] ram [RAM_DEPTH];
  logic [7:0]  fifo [FIFO_DEPTH];

  logic              mmio_sel;
  logic              ram_sel;
  logic              rd_req;
  logic              wr_any;
  logic [1:0]        off;
  logic [RAM_AW-1:0] ram_idx;

  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               ovf;
  logic               full;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               drop;
  logic               ovf_clr;
  logic               cyc_clr;
  logic               scr_wr;

  logic [31:0] cycle_cnt;
  logic [31:0] scratch;
  logic [31:0] status;
  logic [31:0] mmio_rd;

  assign mmio_sel = dce && (daddr[31:16] == MMIO_PAGE);
  assign ram_sel  = dce && !mmio_sel;
  assign rd_req   = dce && (we == 4'b0000);
  assign wr_any   = (we != 4'b0000);
  assign off      = daddr[3:2];
  assign ram_idx  = daddr[RAM_AW+1:2];

  assign full     = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign tx_valid = (count != '0);
  assign tx_data  = tx_valid ? fifo[rd_ptr] : 8'h00;
  assign pop      = tx_valid && tx_ready;

  assign push_req = mmio_sel && (off == 2'd0) && we[0];
  // A full FIFO still takes a byte when the head leaves this cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign ovf_clr  = mmio_sel && (off == 2'd1) && we[0] && din[2];
  assign cyc_clr  = mmio_sel && (off == 2'd2) && wr_any;
  assign scr_wr   = mmio_sel && (off == 2'd3);

  always_ff @(posedge cpu_clk_50M) begin
    if (ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) ram[ram_idx][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (push) fifo[wr_ptr] <= din[7:0];
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // Set wins over a same-cycle clear.
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      cycle_cnt <= '0;
      scratch   <= '0;
    end else begin
      cycle_cnt <= cyc_clr ? 32'd0 : cycle_cnt + 32'd1;
      if (scr_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (we[i]) scratch[8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    status                  = '0;
    status[0]               = (count == '0);
    status[1]               = full;
    status[2]               = ovf;
    status[8 +: FIFO_AW+1]  = count;
  end

  always_comb begin
    mmio_rd = '0;
    unique case (off)
      2'd0: mmio_rd = '0;
      2'd1: mmio_rd = status;
      2'd2: mmio_rd = cycle_cnt;
      2'd3: mmio_rd = scratch;
      default: mmio_rd = '0;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      dm <= '0;
    end else if (rd_req) begin
      dm <= ram_sel ? ram[ram_idx] : mmio_rd;
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: RAM byte lanes, read pipelining,
// TX FIFO fill/overflow/drain, CYCLE counter, async reset.
module tb_data_bus_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] daddr;
  logic        dce;
  logic [3:0]  we;
  logic [31:0] din;
  logic [31:0] dm;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] TXD = 32'hBFD0_0000;
  localparam logic [31:0] STA = 32'hBFD0_0004;
  localparam logic [31:0] CYC = 32'hBFD0_0008;
  localparam logic [31:0] SCR = 32'hBFD0_000C;

  data_bus_responder dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .daddr       (daddr),
    .dce         (dce),
    .we          (we),
    .din         (din),
    .dm          (dm),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic [31:0] a,
                     input logic [3:0] w, input logic [31:0] d);
    dce   = c;
    daddr = a;
    we    = w;
    din   = d;
    @(posedge clk);
    #1;
    dce = 1'b0;
    we  = 4'b0000;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w,
                    input logic [31:0] d);
    cyc(1'b1, a, w, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b1, a, 4'b0000, 32'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 4'b0000, 32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    dce      = 1'b0;
    we       = 4'b0000;
    din      = 32'h0;
    daddr    = 32'h0;
    tx_ready = 1'b0;
    #12;
    chk("rst_dm", dm, 32'h0);
    chk("rst_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_data", {24'b0, tx_data}, 32'h0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // RAM byte lanes
    wr(32'h10, 4'b1111, 32'hAABBCCDD);
    wr(32'h10, 4'b0010, 32'h00001100);
    rd(32'h10);
    chk("ram_lane", dm, 32'hAABB11DD);
    idle();
    chk("dm_hold1", dm, 32'hAABB11DD);
    idle();
    chk("dm_hold2", dm, 32'hAABB11DD);

    // Back-to-back reads
    wr(32'h0, 4'b1111, 32'd1);
    wr(32'h4, 4'b1111, 32'd2);
    wr(32'h8, 4'b1111, 32'd3);
    rd(32'h0);
    chk("pipe0", dm, 32'd1);
    rd(32'h4);
    chk("pipe1", dm, 32'd2);
    rd(32'h8);
    chk("pipe2", dm, 32'd3);

    // FIFO fill and overflow
    for (int i = 0; i < 8; i++) wr(TXD, 4'b0001, 32'h41 + i);
    rd(STA);
    chk("sta_full", dm, 32'h0000_0802);
    wr(TXD, 4'b0001, 32'h49);
    rd(STA);
    chk("sta_ovf", dm, 32'h0000_0806);
    chk("head_valid", {31'b0, tx_valid}, 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_a", {24'b0, tx_data}, 32'h41 + i);
      idle();
    end
    chk("drain_a_end", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    rd(STA);
    chk("sta_empty", dm, 32'h0000_0005);
    wr(STA, 4'b0001, 32'h4);
    rd(STA);
    chk("sta_clr", dm, 32'h0000_0001);

    // Push while full with simultaneous pop
    for (int i = 0; i < 8; i++) wr(TXD, 4'b0001, 32'h50 + i);
    tx_ready = 1'b1;
    wr(TXD, 4'b0001, 32'h5A);
    tx_ready = 1'b0;
    rd(STA);
    chk("sta_pushpop", dm, 32'h0000_0802);
    tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("drain_b", {24'b0, tx_data}, 32'h51 + i);
      idle();
    end
    chk("drain_b_last", {24'b0, tx_data}, 32'h5A);
    idle();
    chk("drain_b_end", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Cycle counter
    wr(CYC, 4'b1000, 32'h0);
    rd(CYC);
    chk("cyc_zero", dm, 32'h0);
    for (int i = 0; i < 8; i++) idle();
    rd(CYC);
    chk("cyc_nine", dm, 32'd9);
    dce   = 1'b1;
    daddr = CYC;
    we    = 4'b0000;
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    @(posedge clk);
    #1;
    chk("cyc_max", dm, 32'hFFFF_FFFF);
    rd(CYC);
    chk("cyc_wrap", dm, 32'h0);

    // Async reset mid-stream
    wr(SCR, 4'b1111, 32'h1234_5678);
    rd(SCR);
    chk("scratch", dm, 32'h1234_5678);
    for (int i = 0; i < 3; i++) wr(TXD, 4'b0001, 32'h60 + i);
    chk("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, tx_valid}, 32'h0);
    chk("arst_dm", dm, 32'h0);
    chk("arst_count", {28'b0, dut.count}, 32'h0);
    #1;
    rst_n = 1'b1;
    rd(SCR);
    chk("post_scratch", dm, 32'h0);
    rd(STA);
    chk("post_sta", dm, 32'h0000_0001);
    rd(32'h10);
    chk("post_ram", dm, 32'hAABB11DD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Responder for the MiniMIPS32 data-memory interface: accepts the core's daddr/dce/we/din requests and returns read data on dm one cycle later, matching the core's WB-stage read timing.
- Decodes two regions: a byte-writable synchronous data RAM, and a small MMIO page.
- The MMIO page holds a transmit byte FIFO with a ready/valid drain port, a status register, a free-running cycle counter and a scratch register.
- Sits beside MiniMIPS32 at SoC top, replacing a bare data RAM.

Parameters:
- RAM_AW, 12, log2 of RAM depth in 32-bit words (4096 words = 16 KB).
- FIFO_AW, 3, log2 of TX FIFO depth in bytes (8 entries).
- MMIO_PAGE, 16'hBFD0, value of daddr[31:16] that selects the MMIO page.

Ports:
- cpu_clk_50M  in  1  clock; all state on rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- daddr  in  32  byte address from core; bits [1:0] ignored.
- dce  in  1  request strobe; no access when 0.
- we  in  4  byte-lane write enables: we[0]->din[7:0] ... we[3]->din[31:24]; all zero = read.
- din  in  32  write data, already lane-aligned by core.
- dm  out  32  registered read data.
- tx_valid  out  1  FIFO head byte available.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  consumer accepts head when tx_valid & tx_ready.

Behaviour:
- Reset (cpu_rst_n=0, async): dm=0, tx_valid=0, tx_data=0, FIFO pointers/count=0, overflow=0, cycle=0, scratch=0. RAM contents are not reset.
- Reset mid-operation flushes the FIFO, and a pending read result is lost (dm=0).
- Decode: mmio_sel = dce & (daddr[31:16]==MMIO_PAGE). ram_sel = dce & ~mmio_sel. RAM index = daddr[RAM_AW+1:2]; higher address bits are aliased.
- Read (dce=1, we=0): dm <= selected word at the next edge, so latency is 1 cycle. Back-to-back reads are allowed every cycle.
- Idle or write cycles: dm holds its previous value.
- RAM write: for each i with we[i]=1, byte i of the word <= din[8i+7:8i] at the edge. Other bytes are untouched.
- A read of the same word in the following cycle returns the new data. No same-cycle read/write exists (we!=0 means write).
- MMIO map, offset = daddr[3:0]; offsets [15:4] are ignored and aliased:
  - 0x0 TXDATA: a write with we[0]=1 pushes din[7:0]. Reads return 0.
  - 0x4 STATUS (read): [0]=empty, [1]=full, [2]=overflow, [8+FIFO_AW:8]=count, others 0. Any write with we[0]=1 and din[2]=1 clears overflow.
  - 0x8 CYCLE: 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF->0. Any write (any we bit) loads 0 at that edge, so the next read returns 0 if issued right after.
  - 0xC SCRATCH: byte-writable 32-bit register, readable.
- MMIO reads return register values before the same-edge update; e.g. a STATUS read during a pop shows the pre-pop count.
- FIFO:
  - Circular buffer, pointers FIFO_AW bits wrapping modulo depth, count FIFO_AW+1 bits.
  - pop = tx_valid & tx_ready.
  - Push is accepted if count<depth, or if count==depth and pop is asserted in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - A push when full with no pop is dropped and sets overflow (sticky). Overflow set and clear in the same cycle resolves to set.
  - tx_valid = (count!=0); tx_data = mem[rd_ptr], combinational from registered state.
  - A pushed byte appears on tx_valid the cycle after the push edge.
  - tx_data is stable while tx_valid & ~tx_ready.
- MMIO writes never touch the RAM; RAM accesses never touch MMIO state.

Test Plan:
- Reset then RAM byte write and readback: write 0xAABBCCDD with we=4'b1111 to 0x00000010, then write din=0x00001100 with we=4'b0010 to the same address, then read 0x00000010 -> dm=0xAABB11DD one cycle after the read request; dm holds that value through the following idle cycles.
- Read latency and pipelining: preload words 1,2,3 at 0x0,0x4,0x8 and issue three consecutive reads -> dm shows 1,2,3 on the three cycles after each request, no bubbles.
- FIFO fill and overflow with tx_ready=0: push 0x41..0x48 (8 bytes) -> STATUS count=8, full=1; push 0x49 -> dropped, overflow=1. Assert tx_ready -> tx_data sequence 0x41..0x48, then tx_valid=0, empty=1. Write STATUS din=0x4 -> overflow=0.
- Push while full with simultaneous pop: FIFO full, tx_ready=1, push 0x5A -> accepted, count stays 8, overflow stays 0, and 0x5A drains last.
- Cycle counter: write CYCLE, read on the next cycle -> 0x00000000; read 10 cycles after the write -> 0x00000009. Force the counter to 0xFFFFFFFF and check it wraps to 0.
- Async reset mid-stream: 3 bytes queued, tx_valid=1; pull cpu_rst_n low between clock edges -> tx_valid=0, dm=0, count=0 immediately, with no clock edge needed. SCRATCH reads 0 after release, and RAM word written earlier still reads back unchanged.
